bot_motion_sched: RTL
=====================

Name: bot_motion_sched

Overview:
Motion-command scheduler that drives the Rojobot MotCtl input from a queue of timed motion steps.
- Each step is a MotCtl value plus a duration counted in BOT register updates (upd_sysregs toggles).
- Sits between the application logic (MicroBlaze/GPIO or game FSM) and the BOT register interface.
- Replaces ad-hoc direct writes of MotCtl.

Parameters:
DEPTH, 8, command FIFO entries; power of 2, minimum 2.
DUR_W, 8, width of the step duration field.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered this cycle
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising clk edge
cmd_motctl  in  8  MotCtl value for the step: {lm_spd[2:0], lm_dir, rm_spd[2:0], rm_dir}
cmd_dur  in  DUR_W  step duration in BOT updates; 0 is treated as 1
abort  in  1  synchronous abort/flush, level-sensitive
upd_sysregs  in  1  BOT update flag; toggles once per BOT register update
Sensors  in  8  BOT sensor register; bit4 = left proximity, bit3 = right proximity
MotCtl  out  8  motor control to the BOT
busy  out  1  high in LOAD or RUN
done_pulse  out  1  one-cycle pulse when the last queued step completes and the FIFO is empty
step_cnt  out  8  count of completed steps; wraps at 255->0
fifo_level  out  log2(DEPTH)+1  number of queued steps
halted  out  1  proximity halt active; 0 when PROX_STOP_EN is absent

Behaviour:
- Reset values:
  - MotCtl, step_cnt, fifo_level, remaining counter = 0.
  - busy, done_pulse, halted = 0.
  - State = IDLE. Internal upd_q = 0.
- Update event: upd_evt = upd_sysregs ^ upd_q, where upd_q is a register of upd_sysregs. One event per toggle, either polarity.
- cmd_ready = (fifo_level < DEPTH) && !abort && !halted.
- FIFO writes occur only on an accepted command.
- FIFO pops occur only in LOAD.
- A push and a pop in the same cycle leave fifo_level unchanged.
- States:
  - IDLE:
    - MotCtl held at 8'h00.
    - If fifo_level > 0, go to LOAD next edge.
  - LOAD:
    - Pop head; MotCtl <= head.motctl.
    - remaining <= (head.dur == 0) ? 1 : head.dur.
    - Go to RUN.
    - upd_evt in this cycle is ignored.
  - RUN, on upd_evt:
    - If remaining > 1: decrement remaining.
    - If remaining == 1: step_cnt++.
      - If fifo_level > 0: go to LOAD; MotCtl holds its value through LOAD.
      - Else: go to IDLE; MotCtl <= 8'h00; done_pulse = 1 for that cycle.
  - HALT: only reachable with PROX_STOP_EN; see below.
- Latency:
  - A command accepted at edge k into an empty FIFO in IDLE drives MotCtl at edge k+2.
  - Step-to-step handoff costs one clk (LOAD) with no gap in MotCtl.
- abort:
  - Priority over every other event.
  - Next edge: state = IDLE, FIFO flushed (fifo_level = 0), MotCtl = 8'h00, remaining = 0, halted = 0.
  - No done_pulse; step_cnt unchanged.
  - Commands cannot be accepted while abort is high.
- Abort while IDLE with an empty FIFO: no observable change.
- Reset mid-step: all outputs return to reset values immediately (asynchronous).
- step_cnt wraps without a flag.
- fifo_level tracks full DEPTH; occupancy DEPTH is distinguishable from 0.

Optional Feature:
PROX_STOP_EN
- Defined:
  - In RUN or LOAD, if Sensors[4] | Sensors[3] is sampled 1, the next edge enters HALT.
  - In HALT: MotCtl = 8'h00, FIFO flushed, halted = 1, busy = 0, cmd_ready = 0, upd_evt ignored.
  - HALT exits to IDLE only via abort.
  - The interrupted step is not counted.
- Not defined:
  - Sensors is ignored, the HALT state does not exist, and halted is tied to 0.

Test Plan:
- Single step: push {8'hA8, dur 3} in IDLE -> MotCtl = 8'hA8 two edges after accept; busy = 1. After 3 upd_sysregs toggles -> MotCtl = 8'h00, one done_pulse, step_cnt = 1.
- Back-to-back steps: push {8'h88, 2}, {8'h28, 1}, {8'hA0, 0} -> MotCtl sequence 88 (2 updates), 28 (1 update), A0 (1 update, dur 0 treated as 1), then 00. step_cnt = 3; exactly one done_pulse; no 00 gap between steps.
- Full FIFO: push DEPTH+1 commands while RUN waits with no toggles -> cmd_ready = 0 after DEPTH accepts, fifo_level = DEPTH. One toggle ending the current step re-asserts cmd_ready after LOAD.
- Abort: assert abort for 1 cycle mid-RUN with 4 queued steps -> next edge MotCtl = 00, fifo_level = 0, busy = 0, no done_pulse, step_cnt unchanged. A cmd_valid held during abort is dropped.
- Toggle in LOAD and async reset: toggle upd_sysregs in the LOAD cycle -> remaining not decremented. Assert reset mid-RUN -> MotCtl = 00 and step_cnt = 0 immediately, without waiting for a clk edge.
- PROX_STOP_EN: drive Sensors = 8'h10 during RUN -> HALT, halted = 1, MotCtl = 00, FIFO flushed, cmd_ready = 0. Pulse abort -> IDLE, halted = 0. Without the macro, the same stimulus has no effect.

Source files
------------

// File: rtl/bot_motion_sched.sv
// rtl/bot_motion_sched.sv - timed MotCtl step scheduler with command FIFO feeding the Rojobot BOT
// Optional proximity halt is compiled in when PROX_STOP_EN is defined.
module bot_motion_sched #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_motctl,
    input  logic [DUR_W-1:0]         cmd_dur,
    input  logic                     abort,
    input  logic                     upd_sysregs,
    input  logic [7:0]               Sensors,
    output logic [7:0]               MotCtl,
    output logic                     busy,
    output logic                     done_pulse,
    output logic [7:0]               step_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     halted
);
    localparam int AW = $clog2(DEPTH);

`ifdef PROX_STOP_EN
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
`endif

    state_t             state;
    logic               upd_q;
    logic               upd_evt;
    logic [DUR_W-1:0]   remaining;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [DUR_W+7:0]   mem [DEPTH];
    logic [DUR_W+7:0]   head;
    logic [DUR_W-1:0]   head_dur;
    logic [7:0]         head_mot;
    logic               push;
    logic               pop;
    logic               unused_sensors;

    assign upd_evt   = upd_sysregs ^ upd_q;
    assign cmd_ready = (fifo_level < (AW+1)'(DEPTH)) && !abort && !halted;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == LOAD);
    assign busy      = (state == LOAD) || (state == RUN);
    assign head      = mem[rd_ptr];
    assign head_dur  = head[DUR_W-1:0];
    assign head_mot  = head[DUR_W+7:DUR_W];

`ifdef PROX_STOP_EN
    logic prox_hit;
    assign prox_hit       = (Sensors[4] | Sensors[3]) && ((state == RUN) || (state == LOAD));
    assign unused_sensors = ^{Sensors[7:5], Sensors[2:0]};
`else
    assign unused_sensors = ^Sensors;
    assign halted         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_motctl, cmd_dur};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            upd_q      <= 1'b0;
            remaining  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            MotCtl     <= 8'h00;
            step_cnt   <= 8'h00;
            done_pulse <= 1'b0;
`ifdef PROX_STOP_EN
            halted     <= 1'b0;
`endif
        end else begin
            upd_q      <= upd_sysregs;
            done_pulse <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                MotCtl     <= 8'h00;
                remaining  <= '0;
`ifdef PROX_STOP_EN
                halted     <= 1'b0;
            end else if (prox_hit) begin
                // Interrupted step is dropped without touching step_cnt.
                state      <= HALT;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                MotCtl     <= 8'h00;
                halted     <= 1'b1;
`endif
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   fifo_level <= fifo_level + 1'b1;
                    2'b01:   fifo_level <= fifo_level - 1'b1;
                    default: fifo_level <= fifo_level;
                endcase

                case (state)
                    IDLE: begin
                        MotCtl <= 8'h00;
                        if (fifo_level != '0) state <= LOAD;
                    end
                    LOAD: begin
                        MotCtl    <= head_mot;
                        remaining <= (head_dur == '0) ? DUR_W'(1) : head_dur;
                        state     <= RUN;
                    end
                    RUN: begin
                        if (upd_evt) begin
                            if (remaining > DUR_W'(1)) begin
                                remaining <= remaining - 1'b1;
                            end else begin
                                step_cnt <= step_cnt + 8'd1;
                                // MotCtl keeps the old value through LOAD so steps join without a stop.
                                if (fifo_level != '0) begin
                                    state <= LOAD;
                                end else begin
                                    state      <= IDLE;
                                    MotCtl     <= 8'h00;
                                    done_pulse <= 1'b1;
                                end
                            end
                        end
                    end
`ifdef PROX_STOP_EN
                    HALT: begin
                        MotCtl <= 8'h00;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
